// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute bundle: the decoded instruction fields offered by ID and
// the load-use hold request returned to IF/ID.
interface ex_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OPW    = 3
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rd_addr;
  logic [OPW-1:0]    id_alu_op;
  logic              id_alu_src;
  logic              id_a_pc;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              load_use_stall;

  // Decode stage side
  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_rd_addr, id_alu_op, id_alu_src, id_a_pc,
           id_reg_write, id_mem_read, id_mem_write,
    input  load_use_stall
  );

  // Execute operand stage side
  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_rd_addr, id_alu_op, id_alu_src, id_a_pc,
           id_reg_write, id_mem_read, id_mem_write,
    output load_use_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use bubble insertion, stall and flush. Feeds the ALU operands.
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OPW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  ex_operand_stage_if.slave id,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [OPW-1:0]    alu_op,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [XLEN-1:0]   ex_store_data
);

  // Index 0 is rs1, index 1 is rs2.
  logic [1:0][REG_AW-1:0] rs_addr_reg;
  logic [1:0][XLEN-1:0]   rs_data_reg;
  logic [1:0][XLEN-1:0]   fwd_rs;
  logic [1:0][REG_AW-1:0] id_rs_addr;
  logic [1:0][XLEN-1:0]   id_rs_data;

  logic              valid_reg;
  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   imm_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [OPW-1:0]    alu_op_reg;
  logic              alu_src_reg;
  logic              a_pc_reg;
  logic              reg_write_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;
  logic              load_use;

  assign id_rs_addr[0] = id.id_rs1_addr;
  assign id_rs_addr[1] = id.id_rs2_addr;
  assign id_rs_data[0] = id.id_rs1_data;
  assign id_rs_data[1] = id.id_rs2_data;

  // Control bits are only meaningful while the slot holds an instruction.
  assign ex_valid     = valid_reg;
  assign ex_reg_write = valid_reg & reg_write_reg;
  assign ex_mem_read  = valid_reg & mem_read_reg;
  assign ex_mem_write = valid_reg & mem_write_reg;
  assign ex_pc        = pc_reg;
  assign ex_rd_addr   = rd_reg;
  assign alu_op       = alu_op_reg;

  // A load in EX whose destination a decoding instruction reads cannot be
  // forwarded in time; ask IF/ID to hold and drop a bubble into EX.
  assign load_use = id.id_valid & ex_mem_read & (rd_reg != '0) &
                    ((rd_reg == id.id_rs1_addr) | (rd_reg == id.id_rs2_addr));
  assign id.load_use_stall = load_use;

  // Per-operand forwarding mux: the younger EX/MEM result wins over MEM/WB,
  // and x0 is never forwarded since it is hard-wired to zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic mem_hit;
    logic wb_hit;
    assign mem_hit    = mem_fwd_en & (mem_fwd_rd != '0) & (mem_fwd_rd == rs_addr_reg[gi]);
    assign wb_hit     = wb_fwd_en & (wb_fwd_rd != '0) & (wb_fwd_rd == rs_addr_reg[gi]);
    assign fwd_rs[gi] = mem_hit ? mem_fwd_data :
                        wb_hit  ? wb_fwd_data  : rs_data_reg[gi];
  end

  assign alu_a         = a_pc_reg ? pc_reg : fwd_rs[0];
  assign alu_b         = alu_src_reg ? imm_reg : fwd_rs[1];
  assign ex_store_data = fwd_rs[1];

  // ID/EX register update: reset, then flush, stall, load-use bubble, load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      rs_addr_reg   <= '0;
      rs_data_reg   <= '0;
      imm_reg       <= '0;
      rd_reg        <= '0;
      alu_op_reg    <= '0;
      alu_src_reg   <= 1'b0;
      a_pc_reg      <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else if (flush) begin
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else if (stall) begin
      // Latch forwarded values so a producer retiring mid-stall is not lost.
      rs_data_reg   <= fwd_rs;
    end else if (load_use) begin
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else begin
      valid_reg     <= id.id_valid;
      pc_reg        <= id.id_pc;
      rs_addr_reg   <= id_rs_addr;
      rs_data_reg   <= id_rs_data;
      imm_reg       <= id.id_imm;
      rd_reg        <= id.id_rd_addr;
      alu_op_reg    <= id.id_alu_op;
      alu_src_reg   <= id.id_alu_src;
      a_pc_reg      <= id.id_a_pc;
      reg_write_reg <= id.id_reg_write;
      mem_read_reg  <= id.id_mem_read;
      mem_write_reg <= id.id_mem_write;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, capture, forwarding priority,
// load-use bubble, stall refresh, flush over stall, AUIPC and reset mid-stall.
module tb_ex_operand_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int OPW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              mem_fwd_en;
  logic [REG_AW-1:0] mem_fwd_rd;
  logic [XLEN-1:0]   mem_fwd_data;
  logic              wb_fwd_en;
  logic [REG_AW-1:0] wb_fwd_rd;
  logic [XLEN-1:0]   wb_fwd_data;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [OPW-1:0]    alu_op;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [XLEN-1:0]   ex_store_data;

  int tests_run    = 0;
  int tests_failed = 0;

  ex_operand_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .OPW(OPW)) id_bus ();

  ex_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .OPW(OPW)) dut (
    .clk           (clk),
    .rst           (rst),
    .id            (id_bus.slave),
    .stall         (stall),
    .flush         (flush),
    .mem_fwd_en    (mem_fwd_en),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_data  (mem_fwd_data),
    .wb_fwd_en     (wb_fwd_en),
    .wb_fwd_rd     (wb_fwd_rd),
    .wb_fwd_data   (wb_fwd_data),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_store_data (ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one decoded instruction on the ID bundle.
  task automatic drive_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [4:0] rd,
                          input logic [2:0] op, input logic src, input logic apc,
                          input logic rw, input logic mr, input logic mw);
    id_bus.id_valid     = v;
    id_bus.id_pc        = pc;
    id_bus.id_rs1_addr  = rs1;
    id_bus.id_rs1_data  = d1;
    id_bus.id_rs2_addr  = rs2;
    id_bus.id_rs2_data  = d2;
    id_bus.id_imm       = imm;
    id_bus.id_rd_addr   = rd;
    id_bus.id_alu_op    = op;
    id_bus.id_alu_src   = src;
    id_bus.id_a_pc      = apc;
    id_bus.id_reg_write = rw;
    id_bus.id_mem_read  = mr;
    id_bus.id_mem_write = mw;
  endtask

  task automatic fwd_off();
    mem_fwd_en = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_en  = 1'b0; wb_fwd_rd  = '0; wb_fwd_data  = '0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " ex_valid"},  {31'd0, ex_valid},     32'd0);
    check({tag, " alu_a"},     alu_a,                 32'd0);
    check({tag, " alu_b"},     alu_b,                 32'd0);
    check({tag, " alu_op"},    {29'd0, alu_op},       32'd0);
    check({tag, " ex_pc"},     ex_pc,                 32'd0);
    check({tag, " ex_rd"},     {27'd0, ex_rd_addr},   32'd0);
    check({tag, " reg_write"}, {31'd0, ex_reg_write}, 32'd0);
    check({tag, " mem_read"},  {31'd0, ex_mem_read},  32'd0);
    check({tag, " mem_write"}, {31'd0, ex_mem_write}, 32'd0);
    check({tag, " store"},     ex_store_data,         32'd0);
    check({tag, " load_use"},  {31'd0, id_bus.load_use_stall}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    fwd_off();
    drive_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check_cleared("reset");
    rst = 1'b0;

    // Plain capture: ADD x6 = x1 + x2 with 5 and 7.
    drive_id(1'b1, 32'h40, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd6, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("cap alu_a",     alu_a,                 32'd5);
    check("cap alu_b",     alu_b,                 32'd7);
    check("cap ex_valid",  {31'd0, ex_valid},     32'd1);
    check("cap ex_pc",     ex_pc,                 32'h40);
    check("cap ex_rd",     {27'd0, ex_rd_addr},   32'd6);
    check("cap reg_write", {31'd0, ex_reg_write}, 32'd1);
    check("cap store",     ex_store_data,         32'd7);

    // Forwarding priority on rs1 = x3.
    drive_id(1'b1, 32'h44, 5'd3, 32'h99, 5'd0, 32'h55, 32'h0, 5'd7, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h10;
    wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd3; wb_fwd_data  = 32'h20;
    #1;
    check("fwd mem beats wb", alu_a,             32'h10);
    check("fwd alu_op",       {29'd0, alu_op},   32'd2);
    mem_fwd_en = 1'b0;
    #1;
    check("fwd wb only",      alu_a,             32'h20);
    wb_fwd_en = 1'b0;
    #1;
    check("fwd none",         alu_a,             32'h99);

    // x0 sources are never forwarded.
    fwd_off();
    drive_id(1'b1, 32'h48, 5'd0, 32'h77, 5'd0, 32'h66, 32'h0, 5'd7, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFF;
    wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'hFF;
    #1;
    check("x0 no fwd a", alu_a, 32'h77);
    check("x0 no fwd b", alu_b, 32'h66);
    fwd_off();

    // Load-use: LW x4, then ADD x5 = x1 + x4.
    drive_id(1'b1, 32'h4C, 5'd1, 32'h100, 5'd0, 32'h0, 32'd8, 5'd4, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("lw mem_read", {31'd0, ex_mem_read}, 32'd1);
    drive_id(1'b1, 32'h50, 5'd1, 32'd5, 5'd4, 32'h0, 32'h0, 5'd5, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu stall", {31'd0, id_bus.load_use_stall}, 32'd1);
    tick();
    check("lu bubble valid",  {31'd0, ex_valid},    32'd0);
    check("lu bubble mem_rd", {31'd0, ex_mem_read}, 32'd0);
    check("lu stall drops",   {31'd0, id_bus.load_use_stall}, 32'd0);
    tick();
    wb_fwd_en = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h1234;
    #1;
    check("lu wb fwd b",  alu_b,             32'h1234);
    check("lu a",         alu_a,             32'd5);
    check("lu valid",     {31'd0, ex_valid}, 32'd1);

    // Stall for 3 edges; forwarders active only in the first stalled cycle.
    fwd_off();
    stall = 1'b1;
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'h1234;
    wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd1; wb_fwd_data  = 32'hAB;
    drive_id(1'b1, 32'h999, 5'd9, 32'h1, 5'd9, 32'h2, 32'h0, 5'd9, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("stall c0 a", alu_a, 32'hAB);
    for (int i = 1; i <= 3; i++) begin
      tick();
      fwd_off();
      #1;
      check($sformatf("stall c%0d a", i),     alu_a,               32'hAB);
      check($sformatf("stall c%0d b", i),     alu_b,               32'h1234);
      check($sformatf("stall c%0d pc", i),    ex_pc,               32'h50);
      check($sformatf("stall c%0d rd", i),    {27'd0, ex_rd_addr}, 32'd5);
      check($sformatf("stall c%0d op", i),    {29'd0, alu_op},     32'd0);
      check($sformatf("stall c%0d valid", i), {31'd0, ex_valid},   32'd1);
    end
    stall = 1'b0;

    // SW then flush together with stall.
    drive_id(1'b1, 32'h60, 5'd2, 32'h200, 5'd3, 32'hCAFE, 32'd4, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("sw mem_write", {31'd0, ex_mem_write}, 32'd1);
    check("sw store",     ex_store_data,         32'hCAFE);
    check("sw alu_b imm", alu_b,                 32'd4);
    drive_id(1'b1, 32'h64, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush valid",     {31'd0, ex_valid},     32'd0);
    check("flush reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("flush mem_write", {31'd0, ex_mem_write}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // AUIPC: a = pc, b = imm.
    drive_id(1'b1, 32'h100, 5'd0, 32'h0, 5'd0, 32'h0, 32'h2000, 5'd10, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("auipc a",     alu_a,             32'h100);
    check("auipc b",     alu_b,             32'h2000);
    check("auipc valid", {31'd0, ex_valid}, 32'd1);

    // Reset asserted while a load-use hazard is being held by a stall.
    drive_id(1'b1, 32'h104, 5'd0, 32'h0, 5'd0, 32'h0, 32'h30, 5'd8, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 32'h108, 5'd8, 32'h0, 5'd0, 32'h0, 32'h0, 5'd11, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    #1;
    check("rst-stall lu", {31'd0, id_bus.load_use_stall}, 32'd1);
    tick();
    check("rst-stall lu held", {31'd0, id_bus.load_use_stall}, 32'd1);
    rst = 1'b1;
    tick();
    check_cleared("rst mid-stall");
    rst = 1'b0; stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
